// File: rtl/tmv_pkg.sv
// Shared definitions for the ternary matrix-vector streaming core:
// weight encodings, FSM state encoding and sizing/saturation helpers.
package tmv_pkg;

  // Two-bit ternary weight codes; 2'b10 is reserved and decodes as zero.
  localparam logic [1:0] W_ZERO = 2'b00;
  localparam logic [1:0] W_POS  = 2'b01;
  localparam logic [1:0] W_NEG  = 2'b11;

  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  // |sum| <= 128*K, so 9 bits for one product plus clog2(K) growth bits.
  function automatic int unsigned acc_width(input int unsigned vlen);
    return 9 + $clog2(vlen);
  endfunction

  // Clamp a signed value into the signed byte range.
  function automatic logic signed [7:0] sat8(input logic signed [31:0] v);
    logic signed [7:0] r;
    if (v > 32'sd127) begin
      r = 8'h7F;
    end else if (v < -32'sd128) begin
      r = 8'h80;
    end else begin
      r = v[7:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/ternary_mac_slice.sv
// One 4-row slice of ternary multiply-accumulate.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   w_i        : packed weights, bits [2j+1:2j] for row j of this slice
//   act_i      : signed activation for this beat
//   en_i       : accumulate this beat
//   clr_i      : clear all four accumulators (wins over en_i)
//   sel_i      : row selected for read-out
//   acc_o      : selected accumulator value
module ternary_mac_slice
  import tmv_pkg::*;
#(
  parameter int unsigned ACC_W = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              w_i,
  input  logic signed [7:0]       act_i,
  input  logic                    en_i,
  input  logic                    clr_i,
  input  logic [1:0]              sel_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [ACC_W-1:0] acc_q  [4];
  logic signed [ACC_W-1:0] term_c [4];

  // Decode each weight into +act, -act or 0.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      term_c[j] = '0;
      case (w_i[2*j +: 2])
        W_POS:   term_c[j] = ACC_W'(act_i);
        W_NEG:   term_c[j] = -ACC_W'(act_i);
        W_ZERO:  term_c[j] = '0;
        default: term_c[j] = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      for (int j = 0; j < 4; j++) acc_q[j] <= '0;
    end else if (en_i) begin
      for (int j = 0; j < 4; j++) acc_q[j] <= acc_q[j] + term_c[j];
    end
  end

  assign acc_o = acc_q[sel_i];

endmodule

// File: rtl/ternary_matvec_stream.sv
// Streaming ternary-weight matrix-vector core behind an 8-bit pin interface.
// Loads a (4*COMPUTE_SLICES) x VECTOR_LEN tile one slice per beat, then
// drains one rescaled, saturated signed byte per row.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   ena        : advance enable, 0 freezes all state
//   ui_in      : packed ternary weights for the current slice
//   uio_in     : signed activation (sampled only on slice-0 beats)
//   uo_out     : registered signed result byte
//   uio_out    : tied to zero
//   uio_oe     : tied to zero, all uio pins are inputs
module ternary_matvec_stream
  import tmv_pkg::*;
#(
  parameter int unsigned COMPUTE_SLICES = 4,
  parameter int unsigned VECTOR_LEN     = 32,
  parameter int unsigned OUT_SHIFT      = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned ROWS  = 4 * COMPUTE_SLICES;
  localparam int unsigned ACC_W = acc_width(VECTOR_LEN);
  localparam int unsigned S_W   = (COMPUTE_SLICES > 1) ? $clog2(COMPUTE_SLICES) : 1;
  localparam int unsigned K_W   = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
  localparam int unsigned IDX_W = $clog2(ROWS);

  state_e state_q, state_d;

  logic [S_W-1:0]   s_q, s_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       x_q, x_d;
  logic [7:0]       uo_q, uo_d;

  logic load_beat_c, drain_beat_c, drain_last_c, tile_last_c;
  logic signed [7:0] act_c;
  logic [COMPUTE_SLICES-1:0] slice_en_c;

  logic signed [ACC_W-1:0] slice_acc [COMPUTE_SLICES];
  logic signed [ACC_W-1:0] drain_acc_c;
  logic signed [ACC_W-1:0] shifted_c;
  logic signed [31:0]      wide_c;

  assign tile_last_c = (k_q == K_W'(VECTOR_LEN - 1)) &&
                       (s_q == S_W'(COMPUTE_SLICES - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_LOAD;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:  if (ena && tile_last_c) state_d = ST_DRAIN;
      ST_DRAIN: if (ena && (idx_q == IDX_W'(ROWS - 1))) state_d = ST_LOAD;
      default:  state_d = ST_LOAD;
    endcase
  end

  // FSM strobes.
  always_comb begin
    load_beat_c  = 1'b0;
    drain_beat_c = 1'b0;
    drain_last_c = 1'b0;
    case (state_q)
      ST_LOAD:  load_beat_c = ena;
      ST_DRAIN: begin
        drain_beat_c = ena;
        drain_last_c = ena && (idx_q == IDX_W'(ROWS - 1));
      end
      default: ;
    endcase
  end

  // The activation is broadcast from the pins on slice 0 and replayed from x_q after.
  assign act_c = (s_q == '0) ? uio_in : x_q;

  for (genvar g = 0; g < COMPUTE_SLICES; g++) begin : g_slice
    assign slice_en_c[g] = load_beat_c && (s_q == S_W'(g));

    ternary_mac_slice #(
      .ACC_W (ACC_W)
    ) u_slice (
      .clk   (clk),
      .rst_n (rst_n),
      .w_i   (ui_in),
      .act_i (act_c),
      .en_i  (slice_en_c[g]),
      .clr_i (drain_last_c),
      .sel_i (idx_q[1:0]),
      .acc_o (slice_acc[g])
    );
  end

  // Drain mux: upper index bits pick the slice, low two bits the row inside it.
  always_comb begin
    drain_acc_c = '0;
    for (int i = 0; i < COMPUTE_SLICES; i++) begin
      if ((idx_q >> 2) == IDX_W'(i)) drain_acc_c = slice_acc[i];
    end
    shifted_c = drain_acc_c >>> OUT_SHIFT;
    wide_c    = 32'(shifted_c);
  end

  // Counter, activation latch and result register next values.
  always_comb begin
    s_d   = s_q;
    k_d   = k_q;
    idx_d = idx_q;
    x_d   = x_q;
    uo_d  = uo_q;
    if (load_beat_c) begin
      if (s_q == '0) x_d = uio_in;
      if (s_q == S_W'(COMPUTE_SLICES - 1)) begin
        s_d = '0;
        k_d = (k_q == K_W'(VECTOR_LEN - 1)) ? '0 : k_q + K_W'(1);
      end else begin
        s_d = s_q + S_W'(1);
      end
    end
    if (drain_beat_c) begin
      uo_d  = sat8(wide_c);
      idx_d = drain_last_c ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q   <= '0;
      k_q   <= '0;
      idx_q <= '0;
      x_q   <= '0;
      uo_q  <= '0;
    end else begin
      s_q   <= s_d;
      k_q   <= k_d;
      idx_q <= idx_d;
      x_q   <= x_d;
      uo_q  <= uo_d;
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: doc/ternary_matvec_stream.md
Name: ternary_matvec_stream

Overview:
Streaming 1.58-bit (ternary-weight) matrix-vector multiplier with a TinyTapeout-style 8-bit pin interface.
- Inputs: packed ternary weights and signed 8-bit activations.
- Accumulates a (4*COMPUTE_SLICES) x VECTOR_LEN tile.
- Outputs: one rescaled, saturated signed byte per row.
- Sits as the compute core behind the chip top level. It generalises the fixed-slice multiplier to parametrised slice count, vector length and output scaling, with a defined load/drain schedule and stall support.

Parameters:
- COMPUTE_SLICES, 4: number of 4-row slices; total rows R = 4*COMPUTE_SLICES.
- VECTOR_LEN, 32: activations per tile (K); must be >= 1.
- OUT_SHIFT, 5: arithmetic right shift applied to each accumulator before saturation to 8 bits.

Ports:
- clk  in  1: single clock, all state on rising edge.
- rst_n  in  1: reset, synchronous, active-low.
- ena  in  1: advance enable; 0 = full stall, all state frozen.
- ui_in  in  8: packed weights for rows 4s..4s+3; bits [2j+1:2j] = weight of row 4s+j.
- uio_in  in  8: signed activation x[k], two's complement.
- uo_out  out  8: signed saturated result byte.
- uio_out  out  8: constant 0.
- uio_oe  out  8: constant 0 (all uio pins are inputs).

Behaviour:
- Weight code: 00=0, 01=+1, 11=-1, 10=reserved, treated as 0.
- ACC_WIDTH = 9 + clog2(VECTOR_LEN), a localparam (14 at default). Overflow is impossible by construction.
- Reset (rst_n=0 at an edge): state=LOAD, k=0, s=0, drain index=0, all accumulators=0, x_reg=0, uo_out=0. Reset takes priority over ena. Reset mid-LOAD or mid-DRAIN aborts the tile with no partial output.
- ena=0: no state, counter, accumulator or uo_out change.
- LOAD state, each edge with ena=1 is one beat:
  - if s==0, the activation is taken from uio_in this beat and also latched into x_reg;
  - if s>0, the activation is x_reg and uio_in is ignored;
  - acc[4s+j] += w_j * act, for j=0..3;
  - s increments; at s==COMPUTE_SLICES-1, s wraps to 0 and k increments;
  - the beat with k==VECTOR_LEN-1 and s==COMPUTE_SLICES-1 moves to DRAIN with k=0, and includes its own contribution.
- A LOAD tile is exactly VECTOR_LEN*COMPUTE_SLICES beats. Host order: for k, for s.
- DRAIN state, each edge with ena=1:
  - uo_out <= sat8(acc[idx] >>> OUT_SHIFT); idx increments.
  - sat8 clamps to [-128, 127].
  - After the edge with idx==R-1: state=LOAD, idx=0, s=0, k=0, all accumulators cleared on that same edge.
- Latency: y[0] is visible on uo_out after the first DRAIN edge, which is the edge following the last LOAD beat. y[R-1] appears R edges after the last LOAD beat.
- uo_out holds its last DRAIN value throughout the next LOAD phase, until the next DRAIN edge.
- No inputs are sampled during DRAIN. Back-to-back tiles: the first LOAD beat of the next tile is the edge after the last DRAIN edge.

Decomposition:
- Package tmv_pkg:
  - weight code constants (W_ZERO=2'b00, W_POS=2'b01, W_NEG=2'b11);
  - state encoding (ST_LOAD, ST_DRAIN);
  - sat8 and ACC_WIDTH helper functions.
- Sub-module ternary_mac_slice, instantiated COMPUTE_SLICES times. Each instance holds 4 accumulators of ACC_WIDTH and has ports: weight byte, activation, slice-enable, clear, plus read-out of one selected accumulator.
- Top level holds the FSM, counters, x_reg, the drain mux and saturation.

Test Plan:
1. All weights 01, all x=+1, default params, OUT_SHIFT=0 override.
   -> all 16 accumulators = 32; uo_out sequence 32 repeated 16 times.
2. All weights 11, all x=-128, OUT_SHIFT=0.
   -> acc = +4096; uo_out saturates to 127 for every row. Same with x=+127 -> acc = -4064, uo_out = -128.
3. Row 0 weight 01, row 5 weight 11, all others 00; x[k]=k; default OUT_SHIFT=5.
   -> acc0 = 496, uo_out[0] = 15.
   -> acc5 = -496, uo_out[5] = -16.
   -> all other rows 0.
4. Reserved code 10 on every weight, random x.
   -> all outputs 0. Also verify uio_in is ignored on s>0 beats by driving garbage there.
5. ena deasserted at random beats in LOAD and DRAIN.
   -> outputs identical to the no-stall run; uo_out frozen while ena=0.
6. rst_n asserted at LOAD beat 50, then a fresh full tile.
   -> results equal the fresh tile alone. Repeat with rst_n asserted mid-DRAIN: uo_out=0 after reset, next tile correct.
